// File: rtl/dual_mode_buf_if.sv
// Request/status bundle for dual_mode_buf. The master drives requests and
// write data; the slave (the buffer) returns read data, count and flags.
interface dual_mode_buf_if #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
);
    logic              mode_i;
    logic              wrreq_i;
    logic [DWIDTH-1:0] data_i;
    logic              rdreq_i;
    logic              clr_err_i;
    logic [DWIDTH-1:0] q_o;
    logic              empty_o;
    logic              full_o;
    logic              almost_empty_o;
    logic              almost_full_o;
    logic [AWIDTH:0]   usedw_o;
    logic              mode_o;
    logic              ovf_o;
    logic              udf_o;

    modport master (
        output mode_i, wrreq_i, data_i, rdreq_i, clr_err_i,
        input  q_o, empty_o, full_o, almost_empty_o, almost_full_o,
               usedw_o, mode_o, ovf_o, udf_o
    );

    modport slave (
        input  mode_i, wrreq_i, data_i, rdreq_i, clr_err_i,
        output q_o, empty_o, full_o, almost_empty_o, almost_full_o,
               usedw_o, mode_o, ovf_o, udf_o
    );
endinterface

// File: rtl/dual_mode_buf.sv
// Buffer that acts as a LIFO or FIFO over one storage array. The mode can
// only change while the buffer is empty, so contents are never reinterpreted.
module dual_mode_buf #(
    parameter int   DWIDTH     = 8,
    parameter int   AWIDTH     = 4,
    parameter logic MODE_RST   = 1'b1,
    parameter int   AFULL_LVL  = (2**AWIDTH) - 4,
    parameter int   AEMPTY_LVL = 2
) (
    input  logic           clk_i,
    input  logic           srst_i,
    dual_mode_buf_if.slave bus
);
    localparam int              DEPTH   = 2**AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] AF_W    = (AWIDTH+1)'(AFULL_LVL);
    localparam logic [AWIDTH:0] AE_W    = (AWIDTH+1)'(AEMPTY_LVL);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH:0]   cnt;
    logic [AWIDTH-1:0] wr_ptr, rd_ptr;
    logic              mode_r, ovf_r, udf_r;
    logic [DWIDTH-1:0] q_r;

    logic              is_empty, is_full, rd_acc, wr_acc, mode_eff;
    logic [AWIDTH-1:0] wp_eff, rp_eff, wr_addr, rd_addr, top_idx;
    logic [AWIDTH:0]   cnt_m1;

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == DEPTH_W);
    assign rd_acc   = bus.rdreq_i & ~is_empty;
    assign wr_acc   = bus.wrreq_i & (~is_full | rd_acc);
    // While empty the requested mode takes effect immediately, so a write
    // landing in the same cycle already follows the new mode.
    assign mode_eff = is_empty ? bus.mode_i : mode_r;
    assign wp_eff   = is_empty ? '0 : wr_ptr;
    assign rp_eff   = is_empty ? '0 : rd_ptr;
    assign cnt_m1   = cnt - (AWIDTH+1)'(1);
    assign top_idx  = cnt_m1[AWIDTH-1:0];

    // Address select: LIFO addresses from the count (top = cnt-1), and a
    // simultaneous read+write overwrites the slot being popped.
    always_comb begin
        wr_addr = wp_eff;
        rd_addr = rp_eff;
        if (mode_eff) begin
            rd_addr = top_idx;
            wr_addr = rd_acc ? top_idx : cnt[AWIDTH-1:0];
        end
    end

    // Control state: count, FIFO pointers, mode, read data, sticky errors.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            mode_r <= MODE_RST;
            q_r    <= '0;
            ovf_r  <= 1'b0;
            udf_r  <= 1'b0;
        end else begin
            mode_r <= mode_eff;
            if (wr_acc && !rd_acc)
                cnt <= cnt + (AWIDTH+1)'(1);
            else if (rd_acc && !wr_acc)
                cnt <= cnt_m1;
            if (mode_eff) begin
                wr_ptr <= wp_eff;
                rd_ptr <= rp_eff;
            end else begin
                wr_ptr <= wp_eff + AWIDTH'(wr_acc);
                rd_ptr <= rp_eff + AWIDTH'(rd_acc);
            end
            if (rd_acc)
                q_r <= mem[rd_addr];
            ovf_r <= (ovf_r & ~bus.clr_err_i) | (bus.wrreq_i & ~wr_acc);
            udf_r <= (udf_r & ~bus.clr_err_i) | (bus.rdreq_i & ~rd_acc);
        end
    end

    // Storage array, no reset; reset only blocks the write.
    always_ff @(posedge clk_i) begin
        if (wr_acc && !srst_i)
            mem[wr_addr] <= bus.data_i;
    end

    assign bus.q_o            = q_r;
    assign bus.usedw_o        = cnt;
    assign bus.empty_o        = is_empty;
    assign bus.full_o         = is_full;
    assign bus.almost_full_o  = (cnt >= AF_W);
    assign bus.almost_empty_o = (cnt <= AE_W);
    assign bus.mode_o         = mode_r;
    assign bus.ovf_o          = ovf_r;
    assign bus.udf_o          = udf_r;
endmodule

// File: tb/tb_dual_mode_buf.sv
// Directed bench for dual_mode_buf with hand-computed expectations.
module tb_dual_mode_buf;
    logic clk_i = 1'b0;
    logic srst_i;
    int   total = 0;
    int   bad   = 0;

    dual_mode_buf_if #(.DWIDTH(8), .AWIDTH(4)) bus ();

    dual_mode_buf #(
        .DWIDTH(8), .AWIDTH(4), .MODE_RST(1'b1), .AFULL_LVL(12), .AEMPTY_LVL(2)
    ) dut (
        .clk_i  (clk_i),
        .srst_i (srst_i),
        .bus    (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs then change 1 time unit after it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        bus.wrreq_i = 1'b0; bus.rdreq_i = 1'b0; bus.clr_err_i = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d);
        bus.wrreq_i = 1'b1; bus.data_i = d; tick(); idle();
    endtask

    task automatic rd();
        bus.rdreq_i = 1'b1; tick(); idle();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " usedw"}, 32'(bus.usedw_o), 0);
        chk({tag, " empty"}, 32'(bus.empty_o), 1);
        chk({tag, " full"},  32'(bus.full_o), 0);
        chk({tag, " aempty"}, 32'(bus.almost_empty_o), 1);
        chk({tag, " afull"}, 32'(bus.almost_full_o), 0);
        chk({tag, " q"},     32'(bus.q_o), 0);
        chk({tag, " ovf"},   32'(bus.ovf_o), 0);
        chk({tag, " udf"},   32'(bus.udf_o), 0);
        chk({tag, " mode"},  32'(bus.mode_o), 1);
    endtask

    initial begin
        srst_i = 1'b1; bus.mode_i = 1'b1; bus.data_i = '0; idle();
        tick(); tick();
        chk_reset_vals("rst");
        srst_i = 1'b0;

        // LIFO basic order
        wr(8'h11); wr(8'h22); wr(8'h33);
        chk("lifo usedw3", 32'(bus.usedw_o), 3);
        rd(); chk("lifo q0", 32'(bus.q_o), 32'h33); chk("lifo u2", 32'(bus.usedw_o), 2);
        rd(); chk("lifo q1", 32'(bus.q_o), 32'h22);
        rd(); chk("lifo q2", 32'(bus.q_o), 32'h11);
        chk("lifo u0", 32'(bus.usedw_o), 0); chk("lifo empty", 32'(bus.empty_o), 1);

        // FIFO fill / overflow / drain
        bus.mode_i = 1'b0; tick();
        chk("fifo mode", 32'(bus.mode_o), 0);
        for (int i = 0; i < 16; i++) begin
            wr(8'(i));
            chk("fifo afull", 32'(bus.almost_full_o), 32'((i + 1) >= 12));
            chk("fifo aempty", 32'(bus.almost_empty_o), 32'((i + 1) <= 2));
        end
        chk("fifo full", 32'(bus.full_o), 1);
        chk("fifo ovf pre", 32'(bus.ovf_o), 0);
        wr(8'hFF);
        chk("fifo ovf", 32'(bus.ovf_o), 1);
        chk("fifo u16", 32'(bus.usedw_o), 16);
        for (int i = 0; i < 16; i++) begin
            rd();
            chk("fifo q", 32'(bus.q_o), 32'(i));
        end
        chk("fifo empty", 32'(bus.empty_o), 1);
        bus.clr_err_i = 1'b1; tick(); idle();
        chk("ovf clr", 32'(bus.ovf_o), 0);

        // LIFO full with simultaneous read+write
        bus.mode_i = 1'b1; tick();
        chk("lifo mode", 32'(bus.mode_o), 1);
        for (int i = 0; i < 15; i++) wr(8'(8'h10 + i));
        wr(8'hA5);
        chk("lf full", 32'(bus.full_o), 1);
        bus.rdreq_i = 1'b1; bus.wrreq_i = 1'b1; bus.data_i = 8'h5A; tick(); idle();
        chk("lf rw q", 32'(bus.q_o), 32'hA5);
        chk("lf rw u", 32'(bus.usedw_o), 16);
        chk("lf rw ovf", 32'(bus.ovf_o), 0);
        rd(); chk("lf top", 32'(bus.q_o), 32'h5A); chk("lf u15", 32'(bus.usedw_o), 15);
        for (int i = 0; i < 15; i++) rd();
        chk("lf bottom", 32'(bus.q_o), 32'h10);
        chk("lf u0", 32'(bus.usedw_o), 0);

        // Underflow and clear
        rd();
        chk("udf set", 32'(bus.udf_o), 1);
        chk("udf q", 32'(bus.q_o), 32'h10);
        chk("udf u", 32'(bus.usedw_o), 0);
        bus.clr_err_i = 1'b1; tick(); idle();
        chk("udf clr", 32'(bus.udf_o), 0);

        // Mode change only when empty
        wr(8'h61); wr(8'h62);
        bus.mode_i = 1'b0; tick();
        chk("mode hold", 32'(bus.mode_o), 1);
        rd(); chk("mode rd0", 32'(bus.q_o), 32'h62);
        rd(); chk("mode rd1", 32'(bus.q_o), 32'h61);
        chk("mode hold2", 32'(bus.mode_o), 1);
        tick();
        chk("mode load", 32'(bus.mode_o), 0);

        // Reset mid-operation with usedw=5 and ovf set
        for (int i = 0; i < 16; i++) wr(8'(8'h80 + i));
        wr(8'hEE);
        for (int i = 0; i < 11; i++) rd();
        chk("pre u5", 32'(bus.usedw_o), 5);
        chk("pre ovf", 32'(bus.ovf_o), 1);
        chk("pre q", 32'(bus.q_o), 32'h8A);
        srst_i = 1'b1; bus.wrreq_i = 1'b1; bus.rdreq_i = 1'b1; tick();
        idle();
        chk_reset_vals("mid rst");
        srst_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dual_mode_buf.md
DUAL_MODE_BUF -- requirements
Module: dual_mode_buf

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter AWIDTH, default 4, address width; depth DEPTH = 2**AWIDTH words.
REQ-003 SHALL have parameter MODE_RST, default 1'b1, mode after reset (1 = LIFO, 0 = FIFO).
REQ-004 SHALL have parameter AFULL_LVL, default DEPTH-4, almost-full threshold in words.
REQ-005 SHALL have parameter AEMPTY_LVL, default 2, almost-empty threshold in words.
REQ-006 SHALL have ports: clk_i  in  1  sole clock, all logic on rising edge.
REQ-007 srst_i  in  1  synchronous active-high reset.
REQ-008 mode_i  in  1  requested mode (1 = LIFO, 0 = FIFO).
REQ-009 wrreq_i  in  1  write request; data_i  in  DWIDTH  write data.
REQ-010 rdreq_i  in  1  read request; q_o  out  DWIDTH  registered read data.
REQ-011 empty_o, full_o, almost_empty_o, almost_full_o  out  1 each  status flags.
REQ-012 usedw_o  out  AWIDTH+1  stored word count, 0..DEPTH.
REQ-013 mode_o  out  1  active mode; ovf_o, udf_o  out  1 each  sticky overflow/underflow; clr_err_i  in  1  clears sticky flags.

Function
REQ-014 Read SHALL be accepted iff usedw_o != 0; write SHALL be accepted iff usedw_o != DEPTH or a read is accepted in the same cycle.
REQ-015 Accepted read SHALL update q_o on the same rising edge (1-cycle latency); q_o SHALL hold its value when no read is accepted.
REQ-016 LIFO: read SHALL return the most recently written word still stored; simultaneous accepted read+write SHALL return the old top and leave data_i as new top.
REQ-017 FIFO: read SHALL return the oldest stored word; read and write pointers SHALL wrap modulo DEPTH; simultaneous accepted read+write SHALL return the old head and append data_i at the tail.
REQ-018 usedw_o SHALL change by +1 per accepted write and -1 per accepted read, net 0 for both.
REQ-019 empty_o = (usedw_o == 0), full_o = (usedw_o == DEPTH), almost_full_o = (usedw_o >= AFULL_LVL), almost_empty_o = (usedw_o <= AEMPTY_LVL), all decoded from the registered count, no extra latency.
REQ-020 Mode register SHALL load mode_i only on edges where usedw_o == 0, resetting both pointers to 0; a write in that cycle SHALL use the new mode; mode_i SHALL be ignored while usedw_o != 0.
REQ-021 Rejected write SHALL leave storage and usedw_o unchanged and set ovf_o; rejected read SHALL leave q_o and usedw_o unchanged and set udf_o.
REQ-022 ovf_o/udf_o SHALL remain set until clr_err_i or srst_i; clr_err_i coincident with a new error SHALL leave the flag set.
REQ-023 Storage SHALL be a DEPTH x DWIDTH array without reset; parameters SHALL satisfy 0 <= AEMPTY_LVL < AFULL_LVL <= DEPTH.

Reset
REQ-024 With srst_i high at a rising edge: usedw_o = 0, empty_o = 1, full_o = 0, almost_empty_o = 1, almost_full_o = 0, q_o = 0, ovf_o = udf_o = 0, mode_o = MODE_RST, pointers = 0.
REQ-025 srst_i SHALL override all requests in the same cycle; reset mid-operation SHALL discard stored contents.

Verification (DWIDTH=8, AWIDTH=4, AFULL_LVL=12, AEMPTY_LVL=2)
REQ-026 LIFO: write 0x11, 0x22, 0x33; then read x3 -> q_o 0x33, 0x22, 0x11, each one cycle after rdreq_i; usedw_o 3->0; empty_o = 1.
REQ-027 FIFO: 16 writes 0x00..0x0F -> almost_full_o at usedw 12, full_o at 16; 17th write ignored, ovf_o = 1; 16 reads return 0x00..0x0F in order.
REQ-028 LIFO full, top = 0xA5: rdreq_i + wrreq_i with 0x5A -> q_o = 0xA5, usedw_o stays 16, ovf_o = 0; next read -> 0x5A.
REQ-029 Empty, rdreq_i alone -> udf_o = 1, q_o unchanged, usedw_o = 0; clr_err_i pulse -> udf_o = 0.
REQ-030 mode_i toggled at usedw_o = 2 -> mode_o unchanged; after two reads (usedw_o = 0) next edge mode_o = mode_i.
REQ-031 srst_i at usedw_o = 5 with ovf_o = 1 -> next cycle all outputs at REQ-024 values.
